// File: rtl/regfile_write_arbiter_if.sv
// Writeback request, register file write port and hazard query bundle for
// regfile_write_arbiter. Requesters and decode use master; the arbiter uses slave.
interface regfile_write_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) ();
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [ADDR_W-1:0] req_addr0;
    logic [ADDR_W-1:0] req_addr1;
    logic [DATA_W-1:0] req_data0;
    logic [DATA_W-1:0] req_data1;
    logic [ADDR_W-1:0] a3;
    logic              we3;
    logic [DATA_W-1:0] wd3;
    logic [ADDR_W-1:0] query_addr;
    logic              query_busy;

    modport master (
        output req_valid, req_addr0, req_addr1, req_data0, req_data1, query_addr,
        input  req_ready, a3, we3, wd3, query_busy
    );

    modport slave (
        input  req_valid, req_addr0, req_addr1, req_data0, req_data1, query_addr,
        output req_ready, a3, we3, wd3, query_busy
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Two-requester writeback arbiter for the register file write port, with 1-entry buffers.
// Define REGFILE_ARB_FIXED_PRIO_EN for fixed priority to requester 0 (default: round-robin).
module regfile_write_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_write_arbiter_if.slave bus
);

    logic [1:0]        full_r;
    logic [ADDR_W-1:0] addr0_r;
    logic [ADDR_W-1:0] addr1_r;
    logic [DATA_W-1:0] data0_r;
    logic [DATA_W-1:0] data1_r;
    logic [ADDR_W-1:0] a3_r;
    logic              we3_r;
    logic [DATA_W-1:0] wd3_r;
`ifndef REGFILE_ARB_FIXED_PRIO_EN
    logic              rr_r;
`endif

    logic [1:0]        grant_s;
    logic [1:0]        ready_s;
    logic [1:0]        load_s;
    logic              busy_s;

    // Arbitration among full buffers
    always_comb begin
        grant_s = 2'b00;
        case (full_r)
            2'b01:   grant_s = 2'b01;
            2'b10:   grant_s = 2'b10;
            2'b11: begin
`ifdef REGFILE_ARB_FIXED_PRIO_EN
                grant_s = 2'b01;
`else
                if (rr_r) begin
                    grant_s = 2'b10;
                end else begin
                    grant_s = 2'b01;
                end
`endif
            end
            default: grant_s = 2'b00;
        endcase
    end

    // Accept handshake; x0 writes are accepted but never buffered
    always_comb begin
        ready_s   = ~full_r | grant_s;
        load_s[0] = bus.req_valid[0] & ready_s[0] & (bus.req_addr0 != {ADDR_W{1'b0}});
        load_s[1] = bus.req_valid[1] & ready_s[1] & (bus.req_addr1 != {ADDR_W{1'b0}});
    end

    // Holding buffers: a same-cycle reload keeps a granted buffer full
    always_ff @(posedge clk) begin
        if (rst) begin
            full_r  <= 2'b00;
            addr0_r <= {ADDR_W{1'b0}};
            addr1_r <= {ADDR_W{1'b0}};
            data0_r <= {DATA_W{1'b0}};
            data1_r <= {DATA_W{1'b0}};
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (load_s[i]) begin
                    full_r[i] <= 1'b1;
                end else if (grant_s[i]) begin
                    full_r[i] <= 1'b0;
                end else begin
                    full_r[i] <= full_r[i];
                end
            end
            if (load_s[0]) begin
                addr0_r <= bus.req_addr0;
                data0_r <= bus.req_data0;
            end
            if (load_s[1]) begin
                addr1_r <= bus.req_addr1;
                data1_r <= bus.req_data1;
            end
        end
    end

`ifndef REGFILE_ARB_FIXED_PRIO_EN
    // Round-robin pointer favours the requester not granted last
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_r <= 1'b0;
        end else if (grant_s[0]) begin
            rr_r <= 1'b1;
        end else if (grant_s[1]) begin
            rr_r <= 1'b0;
        end else begin
            rr_r <= rr_r;
        end
    end
`endif

    // Registered write stage; address/data hold when idle
    always_ff @(posedge clk) begin
        if (rst) begin
            we3_r <= 1'b0;
            a3_r  <= {ADDR_W{1'b0}};
            wd3_r <= {DATA_W{1'b0}};
        end else if (grant_s[0]) begin
            we3_r <= 1'b1;
            a3_r  <= addr0_r;
            wd3_r <= data0_r;
        end else if (grant_s[1]) begin
            we3_r <= 1'b1;
            a3_r  <= addr1_r;
            wd3_r <= data1_r;
        end else begin
            we3_r <= 1'b0;
        end
    end

    // Outstanding-write lookup for decode hazard stalls
    always_comb begin
        busy_s = 1'b0;
        if (bus.query_addr != {ADDR_W{1'b0}}) begin
            busy_s = (full_r[0] && (addr0_r == bus.query_addr)) ||
                     (full_r[1] && (addr1_r == bus.query_addr)) ||
                     (we3_r && (a3_r == bus.query_addr));
        end else begin
            busy_s = 1'b0;
        end
    end

    assign bus.req_ready  = ready_s;
    assign bus.a3         = a3_r;
    assign bus.we3        = we3_r;
    assign bus.wd3        = wd3_r;
    assign bus.query_busy = busy_s;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized and directed bench for regfile_write_arbiter against a queue-based
// model of the buffers, arbitration order and register file contents.
module tb_regfile_write_arbiter;
    localparam int AW = 5;
    localparam int DW = 32;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    logic clk_s = 1'b0;
    logic rst_s;

    always #5 clk_s = ~clk_s;

    regfile_write_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    regfile_write_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk (clk_s),
        .rst (rst_s),
        .bus (bus)
    );

    // Register file fed by the DUT write port
    logic [DW-1:0] rf_r [32] = '{default: 32'h0};
    always @(posedge clk_s) begin
        if (bus.we3 === 1'b1) rf_r[bus.a3] <= bus.wd3;
    end

    ent_t          mq0[$];
    ent_t          mq1[$];
    bit            m_rr;
    bit            m_we;
    logic [AW-1:0] m_a3;
    logic [DW-1:0] m_wd3;
    logic [DW-1:0] m_rf [32] = '{default: 32'h0};

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq0.delete();
        mq1.delete();
        m_rr  = 1'b0;
        m_we  = 1'b0;
        m_a3  = '0;
        m_wd3 = '0;
    endtask

    // One clock cycle: drive, compare against the model, then advance the model
    task automatic step(input bit r, input logic [1:0] v,
                        input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                        input logic [AW-1:0] q);
        int         g;
        logic [1:0] rdy;
        bit         busy;
        ent_t       e;
        @(negedge clk_s);
        rst_s          = r;
        bus.req_valid  = v;
        bus.req_addr0  = a0;
        bus.req_data0  = d0;
        bus.req_addr1  = a1;
        bus.req_data1  = d1;
        bus.query_addr = q;
        #1;
        g = -1;
        if (mq0.size() != 0 && mq1.size() != 0) begin
`ifdef REGFILE_ARB_FIXED_PRIO_EN
            g = 0;
`else
            g = m_rr ? 1 : 0;
`endif
        end else if (mq0.size() != 0) begin
            g = 0;
        end else if (mq1.size() != 0) begin
            g = 1;
        end
        rdy[0] = (mq0.size() == 0) || (g == 0);
        rdy[1] = (mq1.size() == 0) || (g == 1);
        busy = 1'b0;
        if (q != 0) begin
            foreach (mq0[k]) if (mq0[k].a == q) busy = 1'b1;
            foreach (mq1[k]) if (mq1[k].a == q) busy = 1'b1;
            if (m_we && m_a3 == q) busy = 1'b1;
        end
        check_val("req_ready", bus.req_ready, rdy);
        check_val("we3", bus.we3, m_we);
        check_val("a3", bus.a3, m_a3);
        check_val("wd3", bus.wd3, m_wd3);
        check_val("query_busy", bus.query_busy, busy);

        if (m_we) m_rf[m_a3] = m_wd3;
        if (r) begin
            model_reset();
        end else begin
            if (g == 0) begin
                e = mq0.pop_front();
                m_a3 = e.a; m_wd3 = e.d; m_we = 1'b1; m_rr = 1'b1;
            end else if (g == 1) begin
                e = mq1.pop_front();
                m_a3 = e.a; m_wd3 = e.d; m_we = 1'b1; m_rr = 1'b0;
            end else begin
                m_we = 1'b0;
            end
            if (v[0] && rdy[0] && a0 != 0) begin e.a = a0; e.d = d0; mq0.push_back(e); end
            if (v[1] && rdy[1] && a1 != 0) begin e.a = a1; e.d = d1; mq1.push_back(e); end
        end
    endtask

    task automatic idle(input int n, input logic [AW-1:0] q);
        for (int i = 0; i < n; i++) step(1'b0, 2'b00, '0, '0, '0, '0, q);
    endtask

    initial begin
        rst_s          = 1'b1;
        bus.req_valid  = 2'b00;
        bus.req_addr0  = '0;
        bus.req_data0  = '0;
        bus.req_addr1  = '0;
        bus.req_data1  = '0;
        bus.query_addr = '0;
        repeat (2) @(posedge clk_s);
        model_reset();
        step(1'b1, 2'b00, '0, '0, '0, '0, 5'd0);

        // Single uncontested write
        step(1'b0, 2'b01, 5'd5, 32'hDEAD_BEEF, '0, '0, 5'd5);
        idle(4, 5'd5);
        check_val("rf5", rf_r[5], 32'hDEAD_BEEF);

        // Both requesters streaming
        for (int i = 0; i < 8; i++) step(1'b0, 2'b11, 5'd3, 32'h11, 5'd4, 32'h22, 5'd4);
        idle(3, 5'd3);

        // x0 write is swallowed
        step(1'b0, 2'b01, 5'd0, 32'hDEAD_0000, '0, '0, 5'd0);
        idle(3, 5'd0);
        check_val("rf0", rf_r[0], 32'h0);

        // Same-address conflict: port 0 granted first
        step(1'b0, 2'b11, 5'd7, 32'hA, 5'd7, 32'hB, 5'd7);
        idle(4, 5'd7);
        check_val("rf7", rf_r[7], 32'hB);

        // Reset with both buffers full drops them
        step(1'b0, 2'b11, 5'd9, 32'h99, 5'd10, 32'h1010, 5'd9);
        step(1'b1, 2'b00, '0, '0, '0, '0, 5'd10);
        idle(2, 5'd9);
        idle(2, 5'd10);
        check_val("rf9", rf_r[9], 32'h0);
        check_val("rf10", rf_r[10], 32'h0);

        // Requester 0 streams alone
        for (int i = 1; i <= 8; i++) step(1'b0, 2'b01, i[AW-1:0] + 5'd10, 32'h100 + i, '0, '0, 5'd12);
        idle(3, 5'd15);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) == 0),
                 2'($urandom_range(0, 3)),
                 5'($urandom_range(0, 7)), $urandom,
                 5'($urandom_range(0, 7)), $urandom,
                 5'($urandom_range(0, 7)));
        end
        idle(4, 5'd0);
        @(negedge clk_s);
        for (int i = 0; i < 32; i++) check_val($sformatf("rf[%0d]", i), rf_r[i], m_rf[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
